// File: rtl/traffic_pkg.sv
// Shared codes for the T-junction signal group: phases, sub-states, lamp patterns and FSM states.
package traffic_pkg;

   localparam logic [1:0] PH0 = 2'd0;
   localparam logic [1:0] PH1 = 2'd1;
   localparam logic [1:0] PH2 = 2'd2;

   localparam logic [1:0] SS_RY = 2'd0;
   localparam logic [1:0] SS_G  = 2'd1;
   localparam logic [1:0] SS_Y  = 2'd2;
   localparam logic [1:0] SS_R  = 2'd3;

   localparam logic [2:0] LAMP_RED        = 3'b100;
   localparam logic [2:0] LAMP_YELLOW     = 3'b010;
   localparam logic [2:0] LAMP_GREEN      = 3'b001;
   localparam logic [2:0] LAMP_RED_YELLOW = 3'b110;

   typedef enum logic [2:0] {
      StHold,
      StRy,
      StG,
      StY,
      StR,
      StPreempt
   } fsm_state_e;

   function automatic logic [2:0] phase_mask(input logic [1:0] p);
      return 3'b001 << p;
   endfunction

   function automatic logic [1:0] next_phase(input logic [1:0] p);
      return (p == PH2) ? PH0 : p + 2'd1;
   endfunction

   function automatic logic [1:0] state_sub_code(input fsm_state_e s);
      logic [1:0] code;
      case (s)
         StRy:    code = SS_RY;
         StG:     code = SS_G;
         StY:     code = SS_Y;
         default: code = SS_R;
      endcase
      return code;
   endfunction

   function automatic logic [2:0] sub_to_lamp(input logic [1:0] sub);
      logic [2:0] lamp;
      case (sub)
         SS_RY:   lamp = LAMP_RED_YELLOW;
         SS_G:    lamp = LAMP_GREEN;
         SS_Y:    lamp = LAMP_YELLOW;
         default: lamp = LAMP_RED;
      endcase
      return lamp;
   endfunction

endpackage

// File: rtl/traffic_rr_select.sv
// Round-robin pick of the next phase with latched demand, starting after the current phase.
module traffic_rr_select
   import traffic_pkg::*;
(
   input  logic [2:0] pending,
   input  logic [1:0] cur_phase,
   output logic [1:0] sel_phase,
   output logic       any_pending
);

   logic [1:0] cand1;
   logic [1:0] cand2;

   always_comb begin
      cand1       = next_phase(cur_phase);
      cand2       = next_phase(cand1);
      any_pending = |pending;
      if (|(pending & phase_mask(cand1))) begin
         sel_phase = cand1;
      end else if (|(pending & phase_mask(cand2))) begin
         sel_phase = cand2;
      end else begin
         // Current phase is searched last; an invalid code falls back to phase 0.
         sel_phase = (cur_phase == 2'd3) ? PH0 : cur_phase;
      end
   end

endmodule

// File: rtl/traffic_phase_scheduler.sv
// Demand-actuated phase sequencer: latches detector requests, serves phases round-robin,
// bounds green between min/max and forces all-red on emergency preemption.
module traffic_phase_scheduler
   import traffic_pkg::*;
#(
   parameter int unsigned TW    = 5,
   parameter int unsigned RY_T  = 2,
   parameter int unsigned MIN_G = 4,
   parameter int unsigned MAX_G = 12,
   parameter int unsigned Y_T   = 2,
   parameter int unsigned R_T   = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick,
   input  logic [2:0] req,
   input  logic       preempt,
   output logic [1:0] phase,
   output logic [1:0] sub_state,
   output logic       all_red,
   output logic [2:0] pending
);

   localparam logic [TW-1:0] RY_LAST  = TW'(RY_T - 1);
   localparam logic [TW-1:0] MIN_LAST = TW'(MIN_G - 1);
   localparam logic [TW-1:0] MAX_LAST = TW'(MAX_G - 1);
   localparam logic [TW-1:0] Y_LAST   = TW'(Y_T - 1);
   localparam logic [TW-1:0] R_LAST   = TW'(R_T - 1);

   fsm_state_e    state;
   fsm_state_e    state_d;
   logic [TW-1:0] timer;
   logic [TW-1:0] timer_d;
   logic [TW-1:0] timer_inc;
   logic [1:0]    phase_d;
   logic [1:0]    last_phase;
   logic [1:0]    sel_phase;
   logic          any_pending;
   logic          other_pending;
   logic          own_req;
   logic          clr_pend;

   traffic_rr_select u_rr_select (
      .pending     (pending),
      .cur_phase   (last_phase),
      .sel_phase   (sel_phase),
      .any_pending (any_pending)
   );

   always_comb begin
      state_d       = state;
      phase_d       = phase;
      timer_d       = timer;
      clr_pend      = 1'b0;
      timer_inc     = (timer == '1) ? timer : timer + 1'b1;
      other_pending = |(pending & ~phase_mask(phase));
      own_req       = |(req & phase_mask(phase));
      unique case (state)
         StHold: begin
            if (preempt) begin
               state_d = StPreempt;
            end else if (tick && any_pending) begin
               state_d = StRy;
               phase_d = sel_phase;
            end
         end
         StPreempt: begin
            if (!preempt && tick) begin
               if (any_pending) begin
                  state_d = StRy;
                  phase_d = sel_phase;
               end else begin
                  state_d = StHold;
               end
            end
         end
         StRy: begin
            if (preempt) begin
               state_d = StY;
            end else if (tick) begin
               if (timer == RY_LAST) begin
                  state_d  = StG;
                  clr_pend = 1'b1;
               end else begin
                  timer_d = timer_inc;
               end
            end
         end
         StG: begin
            // Preempt is checked before tick so a coincident tick cannot extend green.
            if (preempt) begin
               state_d = StY;
            end else if (tick) begin
               if (other_pending && (timer >= MIN_LAST) && (!own_req || (timer >= MAX_LAST))) begin
                  state_d = StY;
               end else begin
                  timer_d = timer_inc;
               end
            end
         end
         StY: begin
            if (tick) begin
               if (timer == Y_LAST) begin
                  state_d = StR;
               end else begin
                  timer_d = timer_inc;
               end
            end
         end
         StR: begin
            if (tick) begin
               if (timer == R_LAST) begin
                  if (preempt) begin
                     state_d = StPreempt;
                  end else if (any_pending) begin
                     state_d = StRy;
                     phase_d = sel_phase;
                  end else begin
                     state_d = StHold;
                  end
               end else begin
                  timer_d = timer_inc;
               end
            end
         end
         default: begin
            state_d = StHold;
         end
      endcase
      if (state_d != state) begin
         timer_d = '0;
      end
   end

   // last_phase starts at PH2 so the first service after reset lands on phase 0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= StHold;
         phase      <= PH0;
         last_phase <= PH2;
         sub_state  <= SS_R;
         all_red    <= 1'b1;
         timer      <= '0;
         pending    <= 3'b111;
      end else begin
         state     <= state_d;
         phase     <= phase_d;
         timer     <= timer_d;
         sub_state <= state_sub_code(state_d);
         all_red   <= (state_d == StHold) || (state_d == StPreempt);
         if (state_d == StRy && state != StRy) begin
            last_phase <= phase_d;
         end
         if (clr_pend) begin
            pending <= (pending | req) & ~phase_mask(phase);
         end else begin
            pending <= pending | req;
         end
      end
   end

endmodule
